// File: rtl/booth_pkg.sv
// Shared constants and state type for the radix-2 Booth multiplier.
package booth_pkg;
  localparam int WIDTH = 17;
  localparam int STEPS = WIDTH;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// shift right of {A, Q, q_1}.
module booth_step
  import booth_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] acc;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    acc = a;
    case ({q[0], q_1})
      2'b01:   acc = a + m_ext;
      2'b10:   acc = a - m_ext;
      default: acc = a;
    endcase
  end

  // The sign of A is replicated into the vacated top bit.
  assign a_next   = {acc[WIDTH], acc[WIDTH:1]};
  assign q_next   = {acc[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Free-running sequential Booth multiplier: LOAD samples operands, 17 CALC
// steps follow, then the product is published on sum with a done pulse.
//
// state | meaning
// LOAD  | capture operands, clear A, q_1 and step counter
// CALC  | one Booth step per cycle; last step writes sum and pulses done
module booth_multiplier
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   sum,
  output logic                 done
);

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   a_r;
  logic             q_1;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;
  logic             last_step;

  booth_step u_step (
    .a        (a_r),
    .q        (q_r),
    .q_1      (q_1),
    .m        (m_r),
    .a_next   (a_nxt),
    .q_next   (q_nxt),
    .q_1_next (q_1_nxt)
  );

  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = CALC;
      CALC:    if (last_step) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      m_r  <= '0;
      q_r  <= '0;
      a_r  <= '0;
      q_1  <= 1'b0;
      sum  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == LOAD) begin
        m_r <= multiplicand;
        q_r <= multiplier;
        a_r <= '0;
        q_1 <= 1'b0;
        cnt <= '0;
      end else begin
        a_r <= a_nxt;
        q_r <= q_nxt;
        q_1 <= q_1_nxt;
        cnt <= cnt + 1'b1;
        // Product is the low 2*WIDTH bits of {A, Q}; A's extra bit is guard only.
        if (last_step) begin
          sum  <= {a_nxt[WIDTH-1:0], q_nxt};
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: products are predicted when operands
// are driven and compared when done pulses.
module tb_booth_multiplier;

  logic        clk;
  logic        rst;
  logic [16:0] multiplier;
  logic [16:0] multiplicand;
  logic [33:0] sum;
  logic        done;

  int vectors;
  int miscompares;
  logic signed [33:0] sb[$];

  booth_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .sum          (sum),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands (at a negedge) and predict their product.
  task automatic issue(input logic signed [16:0] q, input logic signed [16:0] m);
    logic signed [33:0] p;
    multiplier   = q;
    multiplicand = m;
    p = q * m;
    sb.push_back(p);
  endtask

  // Returns the number of negedges until done is seen, or 0 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    multiplier = 17'd2;
    multiplicand = 17'd1;
    repeat (3) @(negedge clk);
    vectors++;
    if (sum !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_sum got=%0h want=0", sum);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got=%0b want=0", done);
    end
    rst = 1'b0;
  endtask

  // Same operands repeatedly: 2*1 each time, done every 18 cycles.
  task automatic test_period;
    int cyc;
    logic signed [33:0] e;
    for (int k = 0; k < 3; k++) begin
      issue(17'sd2, 17'sd1);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 18) begin
        miscompares++;
        $display("FAIL period_latency[%0d] got=%0d want=18", k, cyc);
      end
      vectors++;
      if (sum !== e) begin
        miscompares++;
        $display("FAIL period_sum[%0d] got=%0h want=%0h", k, sum, e);
      end
    end
  endtask

  task automatic test_chain;
    int cyc;
    logic signed [33:0] e;
    logic signed [33:0] prev;
    prev = 34'sd2;
    for (int k = 3; k <= 6; k++) begin
      issue($signed({1'b0, prev[15:0]}), 17'(k));
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 18 || sum !== e) begin
        miscompares++;
        $display("FAIL chain_x%0d got=%0d cyc=%0d want=%0d", k, sum, cyc, e);
      end
      prev = e;
    end
    vectors++;
    if (sum !== 34'd720) begin
      miscompares++;
      $display("FAIL chain_final got=%0d want=720", sum);
    end
  endtask

  task automatic test_signed_extremes;
    int cyc;
    logic signed [33:0] e;
    int qs[7] = '{-5, -7, 0, -65536, 65535, -65536, 1};
    int ms[7] = '{3, -9, -1, -65536, 65535, 65535, -65536};
    logic [33:0] lit[7] = '{34'h3_FFFF_FFF1, 34'd63, 34'd0, 34'h1_0000_0000,
                            34'h0_FFFE_0001, 34'h3_0001_0000, 34'h3_FFFF_0000};
    for (int k = 0; k < 7; k++) begin
      issue(17'(qs[k]), 17'(ms[k]));
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 18 || sum !== e || sum !== lit[k]) begin
        miscompares++;
        $display("FAIL signed[%0d] %0d*%0d got=%0h cyc=%0d want=%0h", k, qs[k], ms[k], sum, cyc, lit[k]);
      end
    end
  endtask

  task automatic test_mid_calc;
    int cyc;
    logic signed [33:0] e;
    issue(-17'sd123, 17'sd456);
    repeat (5) @(negedge clk);
    multiplier   = 17'd77;
    multiplicand = -17'sd88;
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 13 || sum !== e) begin
      miscompares++;
      $display("FAIL mid_calc_old got=%0h cyc=%0d want=%0h", sum, cyc, e);
    end
    issue(17'sd77, -17'sd88);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 18 || sum !== e) begin
      miscompares++;
      $display("FAIL mid_calc_new got=%0h cyc=%0d want=%0h", sum, cyc, e);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic signed [33:0] e;
    issue(17'sd1000, 17'sd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (sum !== 34'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async got sum=%0h done=%0b want sum=0 done=0", sum, done);
    end
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    vectors++;
    if (sum !== 34'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold got sum=%0h done=%0b want sum=0 done=0", sum, done);
    end
    issue(-17'sd300, 17'sd211);
    rst = 1'b0;
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 18 || sum !== e) begin
      miscompares++;
      $display("FAIL reset_rerun got=%0h cyc=%0d want=%0h", sum, cyc, e);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    multiplier = '0;
    multiplicand = '0;
    test_reset;
    test_period;
    test_chain;
    test_signed_extremes;
    test_mid_calc;
    test_reset_mid;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
